// File: rtl/alu_seq_pkg.sv
// Shared definitions for the two-requester ALU sequencer: op codes, FSM states
// and the op-to-select decode.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_RESP
    } state_t;

    function automatic logic [3:0] op2switch(input op_t op);
        logic [3:0] sw;
        sw = '0;
        case (op)
            OP_ADD:  sw = 4'b0001;
            OP_SUB:  sw = 4'b0010;
            OP_AND:  sw = 4'b0100;
            OP_OR:   sw = 4'b1000;
            default: sw = '0;
        endcase
        return sw;
    endfunction

endpackage

// File: rtl/alu_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = 1'b0;
        grant    = '0;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        if (valid != 2'b00) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one add/sub/and/or ALU between two requesters: arbitrate, register
// operands, pulse the one-hot select, return the result tagged with the id.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   alu_switch,
    output logic [W-1:0] alu_op1,
    output logic [W-1:0] alu_op2,
    input  logic [W-1:0] alu_result,
    output logic [15:0]  ops_done
);

    localparam int unsigned CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    state_t         state;
    logic           last_grant;
    logic           id_q;
    op_t            op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  cnt;
    logic [1:0]     grant;
    logic           grant_id;
    logic           accept;

    rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    always_comb begin
        req0_ready = (state == S_IDLE) && grant[0];
        req1_ready = (state == S_IDLE) && grant[1];
        accept     = (state == S_IDLE) && (grant != 2'b00);
    end

    // Outputs are registered, so each state's outputs appear one cycle after
    // entering it: operands show in the first EXEC cycle, select one cycle
    // later, and the counter spends one extra EXEC cycle raising the select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            alu_switch <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            ops_done   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        op_q       <= op_t'(grant_id ? req1_op : req0_op);
                        a_q        <= grant_id ? req1_a : req0_a;
                        b_q        <= grant_id ? req1_b : req0_b;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    alu_op1 <= a_q;
                    alu_op2 <= b_q;
                    cnt     <= CW'(ALU_LAT);
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_id     <= id_q;
                        rsp_valid  <= 1'b1;
                        alu_switch <= '0;
                        state      <= S_RESP;
                    end else begin
                        alu_switch <= op2switch(op_q);
                        cnt        <= cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
